// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: PC sequencer, single-outstanding memory fetch and instruction FIFO feeding the decoder,
// with redirect, SLEEP/wake and terminal HALT handling.
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            sleep_req,
  input  logic            wake,
  input  logic            halt_req,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [PC_W-1:0] instr_pc,
  input  logic            instr_ready,
  output logic            asleep,
  output logic            halted
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {RUN, SLEEP, HALT} state_t;
  state_t state, state_nxt;
  logic [31:0] data_q [DEPTH];
  logic [PC_W-1:0] pc_q [DEPTH];
  logic [AW-1:0] rd, wr, rd_nxt, wr_nxt;
  logic [CW-1:0] count, cnt_pop, cnt_nxt;
  logic [PC_W-1:0] pc, tgt;
  logic redir, flush, push, pop, issue, req_nxt, drop, drop_nxt;
  assign instr_valid = count != '0;
  assign asleep = state == SLEEP;
  assign halted = state == HALT;
  always_comb begin
    state_nxt = state;
    state_nxt = (halt_req || state == HALT) ? HALT :
                (state == SLEEP && wake) ? RUN :
                (state == RUN && sleep_req && !wake) ? SLEEP : state;
    redir = redirect_valid && state != HALT;
    flush = redir || halt_req || state == HALT;
    push = mem_req && mem_ack && !drop && !flush;
    pop = instr_valid && instr_ready && !flush;
    cnt_pop = count - CW'(pop);
    cnt_nxt = flush ? '0 : cnt_pop + CW'(push);
    rd_nxt = flush ? '0 : rd + AW'(pop);
    wr_nxt = flush ? '0 : wr + AW'(push);
    tgt = redir ? (redirect_pc & ~PC_W'(3)) : pc;
    // a fresh request may leave in the same cycle the previous one is acked
    issue = (!mem_req || mem_ack) && state_nxt == RUN && cnt_nxt < CW'(DEPTH);
    req_nxt = (mem_req && !mem_ack) || issue;
    drop_nxt = mem_req && !mem_ack && (drop || redir);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      count <= '0;
      rd <= '0;
      wr <= '0;
      pc <= RESET_PC;
      mem_req <= 1'b0;
      mem_addr <= RESET_PC;
      drop <= 1'b0;
      instr <= '0;
      instr_pc <= '0;
    end else begin
      state <= state_nxt;
      count <= cnt_nxt;
      rd <= rd_nxt;
      wr <= wr_nxt;
      pc <= issue ? tgt + PC_W'(4) : tgt;
      mem_req <= req_nxt;
      if (issue) mem_addr <= tgt;
      drop <= drop_nxt;
      // head registers only move when a word is present, so an empty FIFO holds the last word
      if (cnt_nxt != '0) begin
        instr <= (cnt_pop == '0) ? mem_rdata : data_q[rd_nxt];
        instr_pc <= (cnt_pop == '0) ? mem_addr : pc_q[rd_nxt];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr] <= mem_rdata;
      pc_q[wr] <= mem_addr;
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed checks of fetch order, backpressure, redirect, sleep, halt, PC wrap and async reset.
module tb_instr_fetch_queue;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  logic mem_req, mem_ack, redirect_valid, sleep_req, wake, halt_req;
  logic instr_valid, instr_ready, asleep, halted;
  logic [31:0] mem_addr, mem_rdata, redirect_pc, instr, instr_pc;
  logic mem_req_b, mem_ack_b, redirect_valid_b, instr_valid_b, asleep_b, halted_b;
  logic [7:0] mem_addr_b, redirect_pc_b, instr_pc_b;
  logic [31:0] mem_rdata_b, instr_b;
  int n_cmp = 0;
  int n_err = 0;
  assign mem_rdata = mem_addr ^ 32'hA5A5_0000;
  assign mem_rdata_b = {24'hA5A500, mem_addr_b};
  instr_fetch_queue dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .sleep_req(sleep_req), .wake(wake), .halt_req(halt_req), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready), .asleep(asleep), .halted(halted)
  );
  instr_fetch_queue #(.DEPTH(4), .PC_W(8), .RESET_PC(8'h00)) dut_b (
    .clk(clk), .reset(reset), .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_ack(mem_ack_b),
    .mem_rdata(mem_rdata_b), .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b),
    .sleep_req(1'b0), .wake(1'b0), .halt_req(1'b0), .instr_valid(instr_valid_b),
    .instr(instr_b), .instr_pc(instr_pc_b), .instr_ready(1'b1), .asleep(asleep_b), .halted(halted_b)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    {mem_ack, redirect_valid, sleep_req, wake, halt_req, instr_ready} = '0;
    redirect_pc = '0;
    {mem_ack_b, redirect_valid_b} = '0;
    redirect_pc_b = '0;
    step();
    reset = 1'b0;
  endtask
  initial begin
    {mem_ack, redirect_valid, sleep_req, wake, halt_req, instr_ready} = '0;
    redirect_pc = '0;
    {mem_ack_b, redirect_valid_b} = '0;
    redirect_pc_b = '0;
    #1 reset = 1'b1;
    #1;
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_ipc", instr_pc, 32'd0);
    chk("rst_sleep_halt", {30'b0, asleep, halted}, 32'd0);
    // 1: streaming fetch
    do_reset();
    mem_ack = 1'b1; instr_ready = 1'b1;
    step();
    chk("t1_addr0", mem_addr, 32'h0);
    chk("t1_valid0", {31'b0, instr_valid}, 32'd0);
    step();
    chk("t1_addr1", mem_addr, 32'h4);
    chk("t1_valid1", {31'b0, instr_valid}, 32'd1);
    chk("t1_ipc1", instr_pc, 32'h0);
    chk("t1_instr1", instr, 32'hA5A5_0000);
    step();
    chk("t1_addr2", mem_addr, 32'h8);
    chk("t1_ipc2", instr_pc, 32'h4);
    chk("t1_instr2", instr, 32'hA5A5_0004);
    step();
    chk("t1_addr3", mem_addr, 32'hC);
    chk("t1_ipc3", instr_pc, 32'h8);
    // 2: backpressure fills the FIFO
    do_reset();
    mem_ack = 1'b1;
    repeat (5) step();
    chk("t2_full_req", {31'b0, mem_req}, 32'd0);
    chk("t2_head", instr_pc, 32'h0);
    step();
    chk("t2_still_idle", {31'b0, mem_req}, 32'd0);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("t2_refill_req", {31'b0, mem_req}, 32'd1);
    chk("t2_refill_addr", mem_addr, 32'h10);
    chk("t2_pop_head", instr_pc, 32'h4);
    step();
    chk("t2_full_again", {31'b0, mem_req}, 32'd0);
    // 3: redirect with a pending request
    do_reset();
    instr_ready = 1'b1;
    step();
    mem_ack = 1'b1;
    repeat (2) step();
    chk("t3_pending", mem_addr, 32'h8);
    mem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h103;
    step();
    redirect_valid = 1'b0;
    chk("t3_flushed", {31'b0, instr_valid}, 32'd0);
    chk("t3_addr_held", mem_addr, 32'h8);
    chk("t3_req_held", {31'b0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    step();
    chk("t3_new_addr", mem_addr, 32'h100);
    chk("t3_drop_valid", {31'b0, instr_valid}, 32'd0);
    chk("t3_hold_ipc", instr_pc, 32'h4);
    step();
    mem_ack = 1'b0;
    chk("t3_tgt_valid", {31'b0, instr_valid}, 32'd1);
    chk("t3_tgt_ipc", instr_pc, 32'h100);
    chk("t3_tgt_instr", instr, 32'hA5A5_0100);
    // 4: sleep and wake
    do_reset();
    instr_ready = 1'b1;
    step();
    mem_ack = 1'b1;
    repeat (3) step();
    chk("t4_pending", mem_addr, 32'hC);
    mem_ack = 1'b0; sleep_req = 1'b1;
    step();
    sleep_req = 1'b0;
    chk("t4_asleep", {31'b0, asleep}, 32'd1);
    chk("t4_req_held", {31'b0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("t4_no_req", {31'b0, mem_req}, 32'd0);
    chk("t4_deliver", instr_pc, 32'hC);
    chk("t4_deliver_v", {31'b0, instr_valid}, 32'd1);
    step();
    chk("t4_still_idle", {31'b0, mem_req}, 32'd0);
    chk("t4_drained", {31'b0, instr_valid}, 32'd0);
    chk("t4_hold_instr", instr, 32'hA5A5_000C);
    wake = 1'b1;
    step();
    wake = 1'b0;
    chk("t4_awake", {31'b0, asleep}, 32'd0);
    chk("t4_wake_addr", mem_addr, 32'h10);
    chk("t4_wake_req", {31'b0, mem_req}, 32'd1);
    sleep_req = 1'b1; wake = 1'b1;
    step();
    sleep_req = 1'b0; wake = 1'b0;
    chk("t4_wake_wins", {31'b0, asleep}, 32'd0);
    // 5: halt
    do_reset();
    step();
    mem_ack = 1'b1;
    repeat (3) step();
    chk("t5_queued", {31'b0, instr_valid}, 32'd1);
    mem_ack = 1'b0; halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("t5_halted", {31'b0, halted}, 32'd1);
    chk("t5_flushed", {31'b0, instr_valid}, 32'd0);
    chk("t5_req_pending", {31'b0, mem_req}, 32'd1);
    mem_ack = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200; wake = 1'b1;
    step();
    mem_ack = 1'b0; redirect_valid = 1'b0; wake = 1'b0;
    chk("t5_req_fell", {31'b0, mem_req}, 32'd0);
    chk("t5_addr_kept", mem_addr, 32'hC);
    chk("t5_no_push", {31'b0, instr_valid}, 32'd0);
    step();
    chk("t5_stay_halt", {31'b0, halted}, 32'd1);
    chk("t5_no_issue", {31'b0, mem_req}, 32'd0);
    do_reset();
    chk("t5_reset_clears", {31'b0, halted}, 32'd0);
    // 6: 8-bit PC wrap and async reset
    do_reset();
    step();
    chk("t6_first", {24'b0, mem_addr_b}, 32'h00);
    mem_ack_b = 1'b1; redirect_valid_b = 1'b1; redirect_pc_b = 8'hFC;
    step();
    redirect_valid_b = 1'b0;
    chk("t6_addr_fc", {24'b0, mem_addr_b}, 32'hFC);
    chk("t6_discard", {31'b0, instr_valid_b}, 32'd0);
    step();
    mem_ack_b = 1'b0;
    chk("t6_wrap", {24'b0, mem_addr_b}, 32'h00);
    chk("t6_ipc", {24'b0, instr_pc_b}, 32'hFC);
    chk("t6_instr", instr_b, 32'hA5A5_00FC);
    step();
    chk("t6_req_mid", {31'b0, mem_req_b}, 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("t6_async_req", {31'b0, mem_req_b}, 32'd0);
    chk("t6_async_addr", {24'b0, mem_addr_b}, 32'h00);
    chk("t6_async_valid", {31'b0, instr_valid_b}, 32'd0);
    chk("t6_async_ipc", {24'b0, instr_pc_b}, 32'h00);
    chk("t6_async_instr", instr_b, 32'h0);
    mem_ack_b = 1'b1;
    step();
    reset = 1'b0;
    step();
    mem_ack_b = 1'b0;
    chk("t6_stray_ack", {31'b0, instr_valid_b}, 32'd0);
    chk("t6_post_req", {31'b0, mem_req_b}, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
